// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: op codes, FSM states, memory depth.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package lsu_pkg;

    // All eight 3-bit codes are assigned. The fault logic still treats anything
    // outside this list as invalid, so a later re-encoding with gaps stays safe.
    typedef enum logic [2:0] {
        LW  = 3'd0,
        LH  = 3'd1,
        LHU = 3'd2,
        LB  = 3'd3,
        LBU = 3'd4,
        SW  = 3'd5,
        SH  = 3'd6,
        SB  = 3'd7
    } lsu_op_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        MERGE = 3'd2,
        WRITE = 3'd3,
        RESP  = 3'd4
    } lsu_state_e;

    localparam int LSU_DEPTH_WORDS = 64;

    function automatic logic is_load(input logic [2:0] op);
        return op inside {LW, LH, LHU, LB, LBU};
    endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Lane select + sign/zero extension for loads, and lane merge for sub-word stores.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
// Ports: op/addr_lo pick the lane; rdata is the memory word; wdata holds store
// data in its low bits; load_data is the extended load result; merge_data is
// rdata with the addressed byte/halfword replaced. Lanes live in bits [31:0].
module lsu_byte_lane
    import lsu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [2:0]   op,
    input  logic [1:0]   addr_lo,
    input  logic [N-1:0] rdata,
    input  logic [N-1:0] wdata,
    output logic [N-1:0] load_data,
    output logic [N-1:0] merge_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{addr_lo, 3'b000} +: 8];
        half_sel = rdata[{addr_lo[1], 4'b0000} +: 16];

        load_data = '0;
        case (op)
            LW:      load_data = rdata;
            LH:      load_data = {{(N-16){half_sel[15]}}, half_sel};
            LHU:     load_data = {{(N-16){1'b0}}, half_sel};
            LB:      load_data = {{(N-8){byte_sel[7]}}, byte_sel};
            LBU:     load_data = {{(N-8){1'b0}}, byte_sel};
            default: load_data = '0;
        endcase

        merge_data = rdata;
        case (op)
            SB:      merge_data[{addr_lo, 3'b000} +: 8]     = wdata[7:0];
            SH:      merge_data[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
            default: merge_data = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit in front of a single-port, combinational-read data memory.
// Latency after accept: loads 2, SW 2, SH/SB 3 (read-merge-write), faults 1.
// Backpressure: req_ready only in IDLE; responses are a one-cycle pulse with no backpressure.
// Ports: req_* request handshake (op/addr/wdata); resp_valid/resp_rdata/fault
// completion; mem_we/mem_addr/mem_wdata/mem_rdata drive the data memory.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int N           = 32,
    parameter int DEPTH_WORDS = LSU_DEPTH_WORDS
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [2:0]   req_op,
    input  logic [N-1:0] req_addr,
    input  logic [N-1:0] req_wdata,
    output logic         resp_valid,
    output logic [N-1:0] resp_rdata,
    output logic         fault,
    output logic         mem_we,
    output logic [N-1:0] mem_addr,
    output logic [N-1:0] mem_wdata,
    input  logic [N-1:0] mem_rdata
);

    localparam logic [N-1:0] DEPTH_LIM = N'(DEPTH_WORDS);

    lsu_state_e   state;
    lsu_state_e   state_nxt;
    logic [2:0]   op_q;
    logic [N-1:0] addr_q;
    logic [N-1:0] wdata_q;
    logic [N-1:0] merged_q;
    logic         accept;
    logic         misalign;
    logic         req_fault;
    logic [N-1:0] load_data;
    logic [N-1:0] merge_data;

    // Fault is judged on the incoming request so a bad request never reaches memory.
    always_comb begin
        misalign = 1'b0;
        case (req_op)
            LW, SW:      misalign = (req_addr[1:0] != 2'b00);
            LH, LHU, SH: misalign = req_addr[0];
            LB, LBU, SB: misalign = 1'b0;
            default:     misalign = 1'b1;
        endcase
        req_fault = misalign || ({2'b00, req_addr[N-1:2]} >= DEPTH_LIM);
    end

    assign accept = (state == IDLE) && req_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_we     = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_fault)            state_nxt = RESP;
                    else if (is_load(req_op)) state_nxt = LOAD;
                    else if (req_op == SW)    state_nxt = WRITE;
                    else                      state_nxt = MERGE;
                end
            end
            LOAD:  state_nxt = RESP;
            MERGE: state_nxt = WRITE;
            WRITE: begin
                mem_we    = 1'b1;
                state_nxt = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Response registers are only updated on the edge entering RESP, so they
    // hold their last value through the following request until it completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            merged_q   <= '0;
            resp_rdata <= '0;
            fault      <= 1'b0;
        end else begin
            if (accept) begin
                op_q    <= req_op;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (state == MERGE) begin
                merged_q <= merge_data;
            end
            if (state == LOAD) begin
                resp_rdata <= load_data;
                fault      <= 1'b0;
            end
            if (state == WRITE) begin
                resp_rdata <= '0;
                fault      <= 1'b0;
            end
            if (accept && req_fault) begin
                resp_rdata <= '0;
                fault      <= 1'b1;
            end
        end
    end

    assign mem_addr  = {addr_q[N-1:2], 2'b00};
    assign mem_wdata = (op_q == SW) ? wdata_q : merged_q;

    lsu_byte_lane #(
        .N(N)
    ) u_byte_lane (
        .op         (op_q),
        .addr_lo    (addr_q[1:0]),
        .rdata      (mem_rdata),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
    import lsu_pkg::*;

    localparam int DEPTH = 64;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        fault;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem     [DEPTH];
    logic [31:0] ref_mem [DEPTH];
    int          wr_cnt;
    int          n_checks;
    int          n_errors;
    logic [29:0] rd_widx;

    load_store_unit #(.N(32), .DEPTH_WORDS(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .fault      (fault),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory: combinational read, write on rising edge.
    always_comb begin
        rd_widx   = mem_addr[31:2];
        mem_rdata = (rd_widx < 30'(DEPTH)) ? mem[rd_widx[5:0]] : 32'h0;
    end

    always @(posedge clk) begin
        if (mem_we) begin
            wr_cnt = wr_cnt + 1;
            if (mem_addr[31:2] < 30'(DEPTH)) mem[mem_addr[7:2]] <= mem_wdata;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference behaviour straight from the architectural rules.
    function automatic void model(input logic [2:0] op, input logic [31:0] addr,
                                  input logic [31:0] wdata, output bit f,
                                  output logic [31:0] rd, output int lat,
                                  output bit wr, output logic [31:0] wword);
        logic [31:0] widx, off, w, b, h, sh;
        bit          bad;
        widx = addr >> 2;
        off  = addr % 4;
        sh   = 8 * off;
        case (op)
            LW, SW:      bad = (off != 0);
            LH, LHU, SH: bad = (off % 2 != 0);
            LB, LBU, SB: bad = 0;
            default:     bad = 1;
        endcase
        f = bad || (widx >= DEPTH);
        rd = 0; wr = 0; wword = 0; lat = 1;
        if (f) return;
        w = ref_mem[widx[5:0]];
        b = (w >> sh) & 32'hFF;
        h = (w >> sh) & 32'hFFFF;
        case (op)
            LW:  begin rd = w; lat = 2; end
            LB:  begin rd = (b >= 128) ? b + 32'hFFFFFF00 : b; lat = 2; end
            LBU: begin rd = b; lat = 2; end
            LH:  begin rd = (h >= 32768) ? h + 32'hFFFF0000 : h; lat = 2; end
            LHU: begin rd = h; lat = 2; end
            SW:  begin wr = 1; wword = wdata; lat = 2; end
            SB:  begin wr = 1; lat = 3;
                       wword = (w & ~(32'hFF << sh)) | ((wdata & 32'hFF) << sh); end
            SH:  begin wr = 1; lat = 3;
                       wword = (w & ~(32'hFFFF << sh)) | ((wdata & 32'hFFFF) << sh); end
            default: ;
        endcase
    endfunction

    task automatic run_txn(input string tag, input logic [2:0] op,
                           input logic [31:0] addr, input logic [31:0] wdata);
        bit          e_f, e_wr;
        logic [31:0] e_rd, e_ww, got_w, got_wa, got_rd, widx;
        int          e_lat, got_lat, wr0;
        logic        got_f;
        model(op, addr, wdata, e_f, e_rd, e_lat, e_wr, e_ww);
        widx    = addr >> 2;
        wr0     = wr_cnt;
        got_lat = 0; got_f = 1'bx; got_rd = 'x; got_w = 'x; got_wa = 'x;
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata;
        for (int i = 0; i < 8 && !req_ready; i++) @(negedge clk);
        check_eq({tag, "/ready"}, 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (mem_we) begin got_w = mem_wdata; got_wa = mem_addr; end
            if (resp_valid) begin
                got_lat = k; got_f = fault; got_rd = resp_rdata;
                break;
            end
        end
        check_eq({tag, "/lat"}, 32'(got_lat), 32'(e_lat));
        check_eq({tag, "/fault"}, 32'(got_f), 32'(e_f));
        check_eq({tag, "/rdata"}, got_rd, e_rd);
        check_eq({tag, "/nwr"}, 32'(wr_cnt - wr0), e_wr ? 32'd1 : 32'd0);
        if (e_wr) begin
            check_eq({tag, "/wdata"}, got_w, e_ww);
            check_eq({tag, "/waddr"}, got_wa, {widx[29:0], 2'b00});
            ref_mem[widx[5:0]] = e_ww;
        end
        @(negedge clk);
        check_eq({tag, "/pulse"}, 32'(resp_valid), 32'd0);
        if (widx < DEPTH) check_eq({tag, "/mem"}, mem[widx[5:0]], ref_mem[widx[5:0]]);
    endtask

    initial begin
        logic [31:0] v, addr;
        int wr0;
        n_checks = 0; n_errors = 0; wr_cnt = 0;
        rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0;
        for (int i = 0; i < DEPTH; i++) begin
            v = $urandom;
            mem[i] = v; ref_mem[i] = v;
        end
        mem[4] = 32'h8899AABB; ref_mem[4] = 32'h8899AABB;

        #3;
        check_eq("rst/ready", 32'(req_ready), 32'd1);
        check_eq("rst/resp_valid", 32'(resp_valid), 32'd0);
        check_eq("rst/fault", 32'(fault), 32'd0);
        check_eq("rst/rdata", resp_rdata, 32'd0);
        check_eq("rst/mem_we", 32'(mem_we), 32'd0);
        check_eq("rst/mem_addr", mem_addr, 32'd0);
        check_eq("rst/mem_wdata", mem_wdata, 32'd0);
        #20;
        @(negedge clk) rst_n = 1'b1;

        // Loads from word 0x10
        run_txn("lb", LB, 32'h11, 32'h0);
        check_eq("lb/const", resp_rdata, 32'hFFFFFFAA);
        run_txn("lbu", LBU, 32'h11, 32'h0);
        check_eq("lbu/const", resp_rdata, 32'h000000AA);
        run_txn("lh", LH, 32'h12, 32'h0);
        check_eq("lh/const", resp_rdata, 32'hFFFF8899);

        // Reset during MERGE of an SB: no write, outputs clear asynchronously
        run_txn("pre_rst", LB, 32'h11, 32'h0);
        wr0 = wr_cnt;
        @(negedge clk);
        req_valid = 1'b1; req_op = SB; req_addr = 32'h12; req_wdata = 32'h12345677;
        @(posedge clk);
        #1 req_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst/mem_we", 32'(mem_we), 32'd0);
        check_eq("arst/resp_valid", 32'(resp_valid), 32'd0);
        check_eq("arst/fault", 32'(fault), 32'd0);
        check_eq("arst/rdata", resp_rdata, 32'd0);
        check_eq("arst/mem_addr", mem_addr, 32'd0);
        check_eq("arst/mem_wdata", mem_wdata, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 check_eq("arst/ready", 32'(req_ready), 32'd1);
        repeat (3) begin
            @(negedge clk);
            check_eq("arst/no_resp", 32'(resp_valid), 32'd0);
        end
        check_eq("arst/nwr", 32'(wr_cnt - wr0), 32'd0);
        check_eq("arst/mem", mem[4], 32'h8899AABB);

        // Byte store merge
        run_txn("sb", SB, 32'h12, 32'h12345677);
        check_eq("sb/const", mem[4], 32'h8877AABB);
        check_eq("sb/rdata0", resp_rdata, 32'd0);

        // Misalignment and range faults
        run_txn("lw_mis", LW, 32'h06, 32'h0);
        check_eq("lw_mis/const", 32'(fault), 32'd1);
        run_txn("sh_mis", SH, 32'h13, 32'hFFFF);
        check_eq("sh_mis/const", 32'(fault), 32'd1);
        run_txn("sw_oor", SW, 32'h100, 32'hDEADBEEF);
        check_eq("sw_oor/const", 32'(fault), 32'd1);
        v = $urandom;
        run_txn("sw_top", SW, 32'hFC, v);
        check_eq("sw_top/const", mem[63], v);

        // Back-to-back: SW then LW with req_valid held high
        v = $urandom;
        @(negedge clk);
        req_valid = 1'b1; req_op = SW; req_addr = 32'h20; req_wdata = v;
        @(posedge clk);
        #1 req_op = LW; req_wdata = 32'h0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check_eq($sformatf("b2b/ready%0d", k), 32'(req_ready), (k == 3) ? 32'd1 : 32'd0);
            check_eq($sformatf("b2b/rv%0d", k), 32'(resp_valid), (k == 2) ? 32'd1 : 32'd0);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check_eq("b2b/lw_busy", 32'(resp_valid), 32'd0);
        @(negedge clk);
        check_eq("b2b/lw_rv", 32'(resp_valid), 32'd1);
        check_eq("b2b/lw_data", resp_rdata, v);
        check_eq("b2b/lw_fault", 32'(fault), 32'd0);
        ref_mem[8] = v;

        // Randomized traffic against the reference model
        for (int t = 0; t < 300; t++) begin
            addr = 32'($urandom_range(0, 69)) * 4 + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) addr = $urandom;
            run_txn("rnd", 3'($urandom_range(0, 7)), addr, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
